sha3_host: RTL

Request-side initiator for the `sha3` digest core. It accepts one message per transaction from an upstream valid/ready stream and drives the core's `req_valid`/`req_ready` handshake. It collects the digest through `res_valid`/`res_ready`, optionally compares it against an expected value, and presents the result downstream. It sits between the system message source and the `sha3` instance, and replaces ad-hoc bench-style sequencing with synthesizable control, a timeout watchdog and pass/fail counters.

---
 rtl/sha3_pkg.sv | 14 +
 rtl/sha3_host_wdog.sv | 37 +++
 rtl/sha3_host.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared types and default widths for the sha3 host block.
package sha3_pkg;

    localparam int SHA3_MDLEN = 256;
    localparam int SHA3_ILEN  = 344;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RES,
        OUT
    } sha3_host_state_t;

endpackage

// File: rtl/sha3_host_wdog.sv
// Transaction watchdog: loads TIMEOUT-1 on clear, counts down while run is high.
module sha3_host_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Zero while running means TIMEOUT cycles have been spent in REQ/WAIT_RES.
    assign expire = run && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha3_host.sv
// Request-side initiator for the sha3 core: message in, digest out,
// optional compare, watchdog and saturating pass/fail counters.
module sha3_host
    import sha3_pkg::*;
#(
    parameter int MDLEN   = SHA3_MDLEN,
    parameter int N       = SHA3_ILEN,
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [N-1:0]     msg_data,
    input  logic [MDLEN-1:0] exp_data,
    input  logic             exp_en,
    output logic [N-1:0]     md_in,
    output logic             req_valid,
    input  logic             req_ready,
    input  logic             req_busy,
    input  logic [MDLEN-1:0] md_out,
    input  logic             res_valid,
    output logic             res_ready,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [MDLEN-1:0] dig_data,
    output logic             dig_match,
    output logic             dig_timeout,
    output logic [CNTW-1:0]  pass_cnt,
    output logic [CNTW-1:0]  fail_cnt,
    output logic             busy
);

    sha3_host_state_t state_q, state_d;

    logic [N-1:0]     md_in_q, md_in_d;
    logic [MDLEN-1:0] exp_q, exp_d;
    logic [MDLEN-1:0] dig_data_q, dig_data_d;
    logic             exp_en_q, exp_en_d;
    logic             dig_match_q, dig_match_d;
    logic             dig_timeout_q, dig_timeout_d;
    logic [CNTW-1:0]  pass_q, pass_d;
    logic [CNTW-1:0]  fail_q, fail_d;

    logic wd_clear, wd_run, wd_expire;
    logic accept, capture, hit, to_exit;

    sha3_host_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wd_clear),
        .run   (wd_run),
        .expire(wd_expire)
    );

    assign msg_ready   = rst_n && (state_q == IDLE);
    assign req_valid   = (state_q == REQ);
    assign res_ready   = (state_q == WAIT_RES);
    assign dig_valid   = (state_q == OUT);
    assign busy        = (state_q != IDLE) || req_busy;
    assign md_in       = md_in_q;
    assign dig_data    = dig_data_q;
    assign dig_match   = dig_match_q;
    assign dig_timeout = dig_timeout_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;

    assign accept   = msg_valid && msg_ready;
    assign wd_clear = accept;
    assign wd_run   = (state_q == REQ) || (state_q == WAIT_RES);
    assign capture  = (state_q == WAIT_RES) && res_valid;
    assign hit      = exp_en_q && (md_out == exp_q);
    // A result arriving on the expiry cycle takes priority over the timeout.
    assign to_exit  = wd_expire && !capture;

    always_comb begin
        state_d       = state_q;
        md_in_d       = md_in_q;
        exp_d         = exp_q;
        exp_en_d      = exp_en_q;
        dig_data_d    = dig_data_q;
        dig_match_d   = dig_match_q;
        dig_timeout_d = dig_timeout_q;
        pass_d        = pass_q;
        fail_d        = fail_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    md_in_d       = msg_data;
                    exp_d         = exp_data;
                    exp_en_d      = exp_en;
                    dig_timeout_d = 1'b0;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d = WAIT_RES;
                end
            end
            OUT: begin
                if (dig_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (capture) begin
            dig_data_d    = md_out;
            dig_match_d   = hit;
            dig_timeout_d = 1'b0;
            state_d       = OUT;
        end

        if (to_exit) begin
            dig_data_d    = '0;
            dig_match_d   = 1'b0;
            dig_timeout_d = 1'b1;
            state_d       = OUT;
        end

        if (exp_en_q && capture && hit && (pass_q != '1)) begin
            pass_d = pass_q + CNTW'(1);
        end

        if (exp_en_q && ((capture && !hit) || to_exit) && (fail_q != '1)) begin
            fail_d = fail_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            md_in_q       <= '0;
            exp_q         <= '0;
            exp_en_q      <= 1'b0;
            dig_data_q    <= '0;
            dig_match_q   <= 1'b0;
            dig_timeout_q <= 1'b0;
            pass_q        <= '0;
            fail_q        <= '0;
        end else begin
            state_q       <= state_d;
            md_in_q       <= md_in_d;
            exp_q         <= exp_d;
            exp_en_q      <= exp_en_d;
            dig_data_q    <= dig_data_d;
            dig_match_q   <= dig_match_d;
            dig_timeout_q <= dig_timeout_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
        end
    end

endmodule
